ifetch_sequencer: RTL and testbench
===================================

Name: ifetch_sequencer

Overview:
- Instruction-fetch controller that sequences the combinational instruction ROM (16-bit word address, 32-bit LEGv8 instruction word).
- Owns the program counter, drives the ROM address and registers the returned word into a one-entry output stage.
- Presents the word to decode with a valid/ready handshake, accepts branch redirects from execute, and halts on the "BR XZR" fill word.

Parameters:
ADDR_W, 16, ROM word-address width; the PC counts in words.
DATA_W, 32, instruction width.
RESET_PC, 16'h0000, PC value after reset and after resume.
HALT_WORD, 32'hD60003E0, encoding that stops fetch (BR XZR, the ROM default).
OFF_W, 26, width of the signed branch offset; B-format imm26.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
rom_address  out  ADDR_W  equals pc_q, combinational from the register.
rom_data  in  DATA_W  ROM word for rom_address, valid in the same cycle.
instr  out  DATA_W  registered instruction.
instr_pc  out  ADDR_W  word address that instr was fetched from.
instr_valid  out  1  instr/instr_pc hold a word not yet accepted.
instr_ready  in  1  decode accepts when instr_valid && instr_ready.
redirect  in  1  execute resolved a taken branch this cycle.
redirect_pc  in  ADDR_W  PC of the taken branch.
redirect_offset  in  OFF_W  signed word offset.
resume  in  1  one-cycle pulse that restarts fetch from HALTED.
halted  out  1  high while in the HALTED state.

Behaviour:
- Clock and reset: single clock `clock`. `reset` is synchronous and active-high, sampled only on the rising edge. Reset has priority over every other input.
- Reset values: pc_q=RESET_PC; instr=0; instr_pc=0; instr_valid=0; halted=0; state=FETCH. Reset asserted mid-operation discards any pending word.
- States:
  - FETCH: normal fetch.
  - DRAIN: halt word is presented; fetch is stopped.
  - HALTED: idle until resume or redirect.
- Load condition: load = (state==FETCH) && (!instr_valid || instr_ready).
- On load: instr<=rom_data; instr_pc<=pc_q; instr_valid<=1; pc_q<=pc_q+1, wrapping modulo 2^ADDR_W (16'hFFFF -> 16'h0000).
- Back-pressure: in FETCH with instr_valid && !instr_ready, all registers hold and pc_q does not advance. No word is lost or duplicated.
- Accept without reload (DRAIN or HALTED): instr_valid<=0.
- Latency:
  - First valid word appears the cycle after reset deasserts.
  - Sustained throughput is 1 word/cycle with ready held high.
- Redirect (highest priority after reset, in any state):
  - target = redirect_pc + sign_extend(redirect_offset), truncated to ADDR_W (wraps).
  - Next cycle: pc_q=target, instr_valid=0, state=FETCH, halted=0.
  - The word fetched in the redirect cycle is discarded, even if instr_ready was high.
  - The target word is valid one cycle after that, giving 1 bubble.
- Halt:
  - A load whose rom_data==HALT_WORD still loads normally (instr_valid=1) and moves the state to DRAIN.
  - pc_q keeps the incremented value.
  - In DRAIN, once the word is accepted (valid&&ready): state=HALTED, halted=1, instr_valid=0.
- Resume: in HALTED, a resume pulse sets pc_q=RESET_PC and state=FETCH; halted drops on the next edge. Resume outside HALTED is ignored.
- Simultaneous events:
  - redirect+resume: redirect wins.
  - redirect in DRAIN: the halt word is flushed and fetch continues at target.
  - Halt word fetched in a redirect cycle: discarded, no halt.
- Internal consistency: rom_address is never X after reset; halted==1 implies instr_valid==0.

Decomposition:
- Shared package `legv8_pkg` holds:
  - ADDR_W and DATA_W.
  - HALT_WORD, named BR_XZR.
  - The 2-bit state enum {FETCH, DRAIN, HALTED}.
  - A function sext_off(offset) returning an ADDR_W-wide value.
- One natural sub-module is `branch_target_adder` (pc + sign-extended offset, wrapped). Everything else stays in one module.

Test Plan:
1. Reset then hold ready=1 with the 10-word copy-loop ROM. Expect instr_pc 0,1,2,... on consecutive cycles, instr at pc0=32'h910193E4, and instr_valid high from the first post-reset cycle.
2. Back-pressure: drop ready for 3 cycles while instr_pc=3. Expect instr and instr_pc to hold at 3, rom_address to hold at 4, and resume at 4 with no skip or duplicate.
3. Redirect: redirect_pc=9 with offset=-7 (26'h3FFFFF9). Expect the next cycle's instr_valid=0, then instr_pc=2, then 3.
4. Halt: let fetch reach address 10, which returns the default D60003E0. Expect instr_valid with that word, no further pc advance, and halted=1 the cycle after acceptance. Pulse resume and expect instr_pc=0 next.
5. Simultaneous: apply redirect (pc=3, offset=6 -> target 9) in the same cycle as the halt-word load and as resume. Expect no halt and the next valid instr_pc=9.
6. Wrap and reset mid-stream:
   - Redirect to 16'hFFFF and expect instr_pc FFFF then 0000.
   - Assert reset while instr_valid=1 and expect instr_valid=0 and rom_address=0 next cycle.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: widths, the halt encoding, the fetch
// state enum and the branch-offset sign-extension helper.
package legv8_pkg;

    localparam int ADDR_W = 16;   // ROM word-address width; the PC counts in words
    localparam int DATA_W = 32;   // instruction width
    localparam int OFF_W  = 26;   // B-format imm26 signed word offset

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [DATA_W-1:0] BR_XZR   = 32'hD60003E0;  // ROM fill word, stops fetch

    typedef enum logic [1:0] {
        FETCH  = 2'd0,   // normal fetch
        DRAIN  = 2'd1,   // halt word presented, fetch stopped
        HALTED = 2'd2    // idle until resume or redirect
    } fetch_state_e;

    // Sign-extend (or truncate) a branch offset to PC width. The signed cast
    // makes the size cast replicate the sign bit when OFF_W < ADDR_W; when
    // OFF_W >= ADDR_W it keeps the low bits, which is the modulo-2^ADDR_W
    // result the PC arithmetic wants anyway.
    function automatic logic [ADDR_W-1:0] sext_off(input logic [OFF_W-1:0] offset);
        return ADDR_W'($signed(offset));
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target: PC of the taken branch plus its sign-extended word offset,
// wrapping modulo 2^ADDR_W.
module branch_target_adder
    import legv8_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [OFF_W-1:0]  offset_i,
    output logic [ADDR_W-1:0] target_o
);

    // Carry out of the top bit is dropped, giving the wrap-around target.
    assign target_o = pc_i + sext_off(offset_i);

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational ROM,
// registers the returned word into a one-entry valid/ready output stage,
// takes branch redirects from execute and halts on the BR XZR fill word.
module ifetch_sequencer
    import legv8_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [OFF_W-1:0]  redirect_offset,
    input  logic              resume,
    output logic              halted
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              instr_valid_q;
    logic              halted_q;
    logic [ADDR_W-1:0] redirect_target;
    logic              load;
    logic              accept;

    branch_target_adder u_branch_target_adder (
        .pc_i     (redirect_pc),
        .offset_i (redirect_offset),
        .target_o (redirect_target)
    );

    // The output stage refills whenever it is empty or being drained this cycle.
    assign load   = (state_q == FETCH) && (!instr_valid_q || instr_ready);
    assign accept = instr_valid_q && instr_ready;
    assign pc_d   = pc_q + ADDR_W'(1);

    // Fetch FSM: reset, then redirect, then the per-state fetch/drain/resume rules.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block
        // and appears nowhere in the sensitivity list.
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else if (redirect) begin
            // The word on rom_data this cycle belongs to the wrong path: drop it.
            state_q       <= FETCH;
            pc_q          <= redirect_target;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (load) begin
                        instr_q       <= rom_data;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_d;
                        if (rom_data == BR_XZR) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state_q       <= HALTED;
                        halted_q      <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_q  <= FETCH;
                        pc_q     <= RESET_PC;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign rom_address = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Self-checking bench for ifetch_sequencer: directed walk through the fetch,
// back-pressure, redirect, halt, resume, wrap and reset scenarios, followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_ifetch_sequencer;
    import legv8_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [OFF_W-1:0]  redirect_offset;
    logic              resume;
    logic              halted;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state: program counter, the pending output word, and
    // two flags for "halt word handed out" and "halted".
    int          m_pc;
    bit          m_has;
    logic [31:0] m_word;
    int          m_wpc;
    bit          m_stopped;
    bit          m_halted;

    // Ten-word copy loop at 0..9; BR XZR fill from 10 to 0xFF; above that a
    // hashed pattern that is never the halt word.
    logic [31:0] prog [10] = '{
        32'h910193E4, 32'hAA1F03E9, 32'hF8408485, 32'hF80084A5, 32'hD1000421,
        32'hB4000061, 32'h91002129, 32'h17FFFFFB, 32'hAA0903E0, 32'hD65F03C0
    };

    ifetch_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .rom_address     (rom_address),
        .rom_data        (rom_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .redirect_offset (redirect_offset),
        .resume          (resume),
        .halted          (halted)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom(input logic [15:0] a);
        logic [31:0] w;
        if (a < 16'd10) begin
            w = prog[int'(a)];
        end else if (a < 16'h0100) begin
            w = BR_XZR;
        end else begin
            w = {a, ~a} ^ 32'h5A5A0F0F;
            if (w == BR_XZR) w = w ^ 32'h1;
        end
        return w;
    endfunction

    always_comb rom_data = rom(rom_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Reference model, advanced on every rising edge from the inputs the
    // bench drives (inputs change only on the falling edge).
    always @(posedge clock) begin : p_model
        int          off;
        logic [31:0] w;
        if (reset) begin
            m_pc = 0; m_has = 0; m_word = 0; m_wpc = 0; m_stopped = 0; m_halted = 0;
        end else if (redirect) begin
            off       = int'($signed(redirect_offset));
            m_pc      = (int'(redirect_pc) + off) & 32'hFFFF;
            m_has     = 0;
            m_stopped = 0;
            m_halted  = 0;
        end else if (m_halted) begin
            if (resume) begin
                m_pc     = 0;
                m_halted = 0;
            end
        end else if (m_stopped) begin
            if (m_has && instr_ready) begin
                m_has     = 0;
                m_stopped = 0;
                m_halted  = 1;
            end
        end else if (!m_has || instr_ready) begin
            w         = rom(16'(m_pc));
            m_word    = w;
            m_wpc     = m_pc;
            m_has     = 1;
            m_stopped = (w == BR_XZR);
            m_pc      = (m_pc + 1) & 32'hFFFF;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("cmp_valid", 32'(instr_valid), 32'(m_has));
            check("cmp_halted", 32'(halted), 32'(m_halted));
            check("cmp_rom_address", 32'(rom_address), m_pc & 32'hFFFF);
            check("cmp_halt_idle", 32'(halted && instr_valid), 32'h0);
            if (m_has) begin
                check("cmp_instr", instr, m_word);
                check("cmp_instr_pc", 32'(instr_pc), m_wpc & 32'hFFFF);
            end
        end
    end

    task automatic wait_pc(input logic [15:0] target);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid && instr_pc == target) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("reach_instr_pc", 32'(seen), 32'h1);
    endtask

    initial begin
        reset = 1; instr_ready = 1; redirect = 0; resume = 0;
        redirect_pc = '0; redirect_offset = '0;
        tick(); tick();
        cmp_en = 1;
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_rom_address", 32'(rom_address), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", 32'(instr_pc), 32'h0);

        // Straight-line fetch with ready held high.
        reset = 0;
        tick();
        check("first_valid", 32'(instr_valid), 32'h1);
        check("first_pc", 32'(instr_pc), 32'h0);
        check("first_word", instr, 32'h910193E4);
        check("first_rom_address", 32'(rom_address), 32'h1);
        tick(); check("seq_pc1", 32'(instr_pc), 32'h1);
        tick(); check("seq_pc2", 32'(instr_pc), 32'h2);
        tick(); check("seq_pc3", 32'(instr_pc), 32'h3);

        // Back-pressure for three cycles while pc 3 is presented.
        instr_ready = 0;
        repeat (3) begin
            tick();
            check("bp_instr_pc", 32'(instr_pc), 32'h3);
            check("bp_rom_address", 32'(rom_address), 32'h4);
            check("bp_valid", 32'(instr_valid), 32'h1);
        end
        instr_ready = 1;
        tick(); check("bp_resume_pc4", 32'(instr_pc), 32'h4);

        // Redirect 9 + (-7) = 2, with one bubble.
        redirect = 1; redirect_pc = 16'd9; redirect_offset = 26'h3FFFFF9;
        tick();
        redirect = 0;
        check("redir_bubble", 32'(instr_valid), 32'h0);
        check("redir_rom_address", 32'(rom_address), 32'h2);
        tick(); check("redir_pc2", 32'(instr_pc), 32'h2);
        tick(); check("redir_pc3", 32'(instr_pc), 32'h3);

        // Run into the fill word at address 10, then halt and resume.
        wait_pc(16'd10);
        check("halt_word", instr, 32'hD60003E0);
        check("halt_rom_address", 32'(rom_address), 32'd11);
        instr_ready = 0;
        tick();
        check("drain_no_advance", 32'(rom_address), 32'd11);
        check("drain_valid", 32'(instr_valid), 32'h1);
        check("drain_not_halted", 32'(halted), 32'h0);
        instr_ready = 1;
        tick();
        check("halted_set", 32'(halted), 32'h1);
        check("halted_valid", 32'(instr_valid), 32'h0);
        tick();
        check("halted_hold", 32'(halted), 32'h1);
        check("halted_rom_address", 32'(rom_address), 32'd11);
        resume = 1;
        tick();
        resume = 0;
        check("resume_halted", 32'(halted), 32'h0);
        check("resume_rom_address", 32'(rom_address), 32'h0);
        tick();
        check("resume_pc0", 32'(instr_pc), 32'h0);
        check("resume_valid", 32'(instr_valid), 32'h1);

        // Redirect + resume in the cycle that loads the halt word: no halt.
        wait_pc(16'd9);
        check("simul_rom_address", 32'(rom_address), 32'd10);
        redirect = 1; redirect_pc = 16'd3; redirect_offset = 26'd6; resume = 1;
        tick();
        redirect = 0; resume = 0;
        check("simul_bubble", 32'(instr_valid), 32'h0);
        check("simul_no_halt", 32'(halted), 32'h0);
        tick(); check("simul_pc9", 32'(instr_pc), 32'h9);
        tick(); check("simul_pc10", 32'(instr_pc), 32'd10);

        // Redirect while draining the halt word flushes it.
        redirect = 1; redirect_pc = 16'd0; redirect_offset = 26'd2;
        tick();
        redirect = 0;
        check("drain_redir_valid", 32'(instr_valid), 32'h0);
        check("drain_redir_halted", 32'(halted), 32'h0);
        tick(); check("drain_redir_pc2", 32'(instr_pc), 32'h2);

        // PC wrap 0xFFFF -> 0x0000.
        redirect = 1; redirect_pc = 16'hFFFE; redirect_offset = 26'd1;
        tick();
        redirect = 0;
        check("wrap_rom_address", 32'(rom_address), 32'hFFFF);
        tick(); check("wrap_pc_ffff", 32'(instr_pc), 32'hFFFF);
        tick(); check("wrap_pc_0000", 32'(instr_pc), 32'h0000);
        check("wrap_valid", 32'(instr_valid), 32'h1);

        // Reset in mid-stream discards the pending word.
        reset = 1;
        tick();
        reset = 0;
        check("midrst_valid", 32'(instr_valid), 32'h0);
        check("midrst_rom_address", 32'(rom_address), 32'h0);

        // Randomized traffic; the model does all the checking.
        repeat (3000) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) begin
                redirect_pc     = 16'($urandom);
                redirect_offset = 26'($urandom);
            end else begin
                redirect_pc     = 16'($urandom_range(0, 20));
                redirect_offset = 26'($urandom_range(0, 30)) - 26'd15;
            end
            resume = ($urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
